// File: rtl/led_pkg.sv
// Shared definitions for the LED bank arbiter: FSM state type and small helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   led_state_t  - two-state display FSM encoding (IDLE: LEDs dark, SHOW: pattern driven)
//   idx_width()  - index width for a requester count, never narrower than 1 bit
package led_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } led_state_t;

    // Width of a requester index. Kept at one bit minimum so a degenerate
    // single-requester build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first set request searched upward from last_idx+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used in a given cycle.
//
// Ports:
//   req       in  NUM_REQ  request vector
//   last_idx  in  IDX_W    index granted most recently (lowest priority this round)
//   grant     out NUM_REQ  one-hot winner, all zero when req is zero
//   grant_idx out IDX_W    binary index of the winner, zero when req is zero
module rr_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // One spare bit so last_idx + offset cannot overflow before the wrap.
    localparam int CW = IDX_W + 1;

    always_comb begin
        logic          found;
        logic [CW-1:0] cand;

        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;

        // Offsets 1..NUM_REQ visit every requester once; the last offset is
        // last_idx itself, so the previous winner still wins if it is alone.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_idx} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Shares one LED bank among NUM_REQ requesters, showing each granted pattern for a sampled hold time.
// Latency: req_ready in the same cycle as req_valid (when arbitrating); led/active/grant_idx one cycle later.
// Backpressure: req_ready only in IDLE or the final SHOW cycle with enable=1; requesters hold valid until ready.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   enable       permits new grants; never cuts short a display already running
//   hold_cycles  display length in cycles for the next grant (0 behaves as 1)
//   req_valid    per-requester pattern valid
//   req_pattern  requester i pattern in bits [i*LED_WIDTH +: LED_WIDTH]
//   req_ready    one-hot transfer strobe, combinational
//   led          registered LED drive, zero when idle
//   grant_idx    registered index of the requester shown most recently
//   active       registered, high while a pattern is shown
module led_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LED_WIDTH  = 8,
    parameter int HOLD_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [HOLD_WIDTH-1:0]         hold_cycles,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*LED_WIDTH-1:0]  req_pattern,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [LED_WIDTH-1:0]          led,
    output logic [idx_width(NUM_REQ)-1:0] grant_idx,
    output logic                          active
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // ---------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------
    led_state_t            state_q,  state_d;
    logic [HOLD_WIDTH-1:0] hold_q,   hold_d;    // SHOW cycles left after the current one
    logic [LED_WIDTH-1:0]  led_q,    led_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;     // visible grant index
    logic [IDX_W-1:0]      last_q,   last_d;    // round-robin pointer
    logic                  active_q, active_d;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_cycle;
    logic                  transfer;
    logic [HOLD_WIDTH-1:0] hold_load;
    logic [LED_WIDTH-1:0]  win_pattern;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .last_idx  (last_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // A grant may land in IDLE or in the last SHOW cycle; the latter gives
    // back-to-back patterns with no dark cycle in between. hold_q is always
    // zero in IDLE, so the final-cycle test alone would also cover IDLE, but
    // the explicit state term keeps the intent readable.
    assign arb_cycle = enable && ((state_q == IDLE) || (hold_q == '0));

    // rst_n gates the strobe so nothing transfers while reset is held, even
    // though the registers are already forced to IDLE.
    assign req_ready = (rst_n && arb_cycle) ? arb_grant : '0;
    assign transfer  = |(req_ready & req_valid);

    // hold_cycles is only looked at here, at the grant; later changes are ignored.
    assign hold_load = (hold_cycles == '0) ? '0 : (hold_cycles - HOLD_WIDTH'(1));

    assign win_pattern = req_pattern[int'(arb_idx)*LED_WIDTH +: LED_WIDTH];

    // ---------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        led_d    = led_q;
        idx_d    = idx_q;
        last_d   = last_q;
        active_d = active_q;

        if (transfer) begin
            state_d  = SHOW;
            hold_d   = hold_load;
            led_d    = win_pattern;
            idx_d    = arb_idx;
            last_d   = arb_idx;
            active_d = 1'b1;
        end else begin
            case (state_q)
                SHOW: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_WIDTH'(1);
                    end else begin
                        // Final cycle with nobody to take over: go dark but
                        // leave grant_idx pointing at the last requester shown.
                        state_d  = IDLE;
                        led_d    = '0;
                        active_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    hold_d   = '0;
                    led_d    = '0;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    // Reset parks the pointer on the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            led_q    <= '0;
            idx_q    <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            active_q <= active_d;
        end
    end

    assign led       = led_q;
    assign grant_idx = idx_q;
    assign active    = active_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed and random checks of led_arbiter against a cycle-count reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_led_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 24;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [H-1:0]   hold_cycles;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_pattern;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   led;
    logic [1:0]     grant_idx;
    logic           active;

    always #5 clk = ~clk;

    led_arbiter #(
        .NUM_REQ    (N),
        .LED_WIDTH  (W),
        .HOLD_WIDTH (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .hold_cycles (hold_cycles),
        .req_valid   (req_valid),
        .req_pattern (req_pattern),
        .req_ready   (req_ready),
        .led         (led),
        .grant_idx   (grant_idx),
        .active      (active)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: remaining display cycles, not an FSM state.
    // m_rem == 0 -> dark; m_rem == 1 -> last display cycle; > 1 -> mid display.
    logic [W-1:0] m_led;
    logic [1:0]   m_idx;
    int           m_last;
    int           m_rem;
    logic         m_active;

    logic [N-1:0] exp_ready_v;
    logic [N-1:0] obs_ready;
    logic [W-1:0] obs_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_led    = '0;
        m_idx    = '0;
        m_last   = N - 1;
        m_rem    = 0;
        m_active = 1'b0;
    endtask

    // Who should be offered ready right now, by the round-robin rule.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (rst_n && enable && m_rem <= 1) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (req_valid[i] && r == '0) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic step(input string tag);
        @(negedge clk);
        exp_ready_v = model_ready();
        obs_ready   = req_ready;
        obs_led     = led;
        check({tag, "/ready"},     32'(req_ready), 32'(exp_ready_v));
        check({tag, "/led"},       32'(led),       32'(m_led));
        check({tag, "/active"},    32'(active),    32'(m_active));
        check({tag, "/grant_idx"}, 32'(grant_idx), 32'(m_idx));
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else if (exp_ready_v != '0) begin
            for (int i = 0; i < N; i++) begin
                if (exp_ready_v[i]) begin
                    m_led  = req_pattern[i*W +: W];
                    m_idx  = 2'(i);
                    m_last = i;
                end
            end
            m_active = 1'b1;
            m_rem    = (hold_cycles == '0) ? 1 : int'(hold_cycles);
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_led    = '0;
                m_active = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        step("rst_hold");
        step("rst_hold");
        rst_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int cnt;
        int zero_cnt;
        int order[$];

        rst_n       = 1'b0;
        enable      = 1'b1;
        hold_cycles = 24'd3;
        req_valid   = 4'b0001;
        req_pattern = {8'h44, 8'h33, 8'h22, 8'hA5};
        reset_model();
        #2;

        // Reset: valid present while reset held must not be offered ready.
        step("rst_a");
        step("rst_b");
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        step("idle");

        // Single grant, hold 3.
        req_valid = 4'b0001;
        step("t1_grant");
        check("t1_ready_onehot", 32'(obs_ready), 32'h1);
        req_valid = 4'b0000;
        cnt = 0;
        for (int s = 0; s < 5; s++) begin
            step("t1_show");
            if (obs_led == 8'hA5) cnt++;
        end
        check("t1_len", 32'(cnt), 32'd3);

        // Round robin, back-to-back.
        req_pattern = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        hold_cycles = 24'd2;
        req_valid   = 4'b1111;
        zero_cnt    = 0;
        for (int s = 0; s < 10; s++) begin
            step("rr");
            if (obs_ready != '0) order.push_back(onehot_idx(obs_ready));
            if (s > 0 && obs_led == 8'h00) zero_cnt++;
        end
        check("rr_count", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            check("rr_0", 32'(order[0]), 32'd0);
            check("rr_1", 32'(order[1]), 32'd1);
            check("rr_2", 32'(order[2]), 32'd2);
            check("rr_3", 32'(order[3]), 32'd3);
            check("rr_4", 32'(order[4]), 32'd0);
        end
        check("rr_no_gap", 32'(zero_cnt), 32'd0);
        req_valid = 4'b0000;
        repeat (3) step("rr_drain");

        // hold = 0 behaves as 1: a grant every cycle.
        hold_cycles = 24'd0;
        req_valid   = 4'b1111;
        cnt = 0;
        for (int s = 0; s < 6; s++) begin
            step("h0");
            if (obs_ready != '0) cnt++;
        end
        check("h0_grants", 32'(cnt), 32'd6);
        req_valid = 4'b0000;
        repeat (2) step("h0_drain");

        // hold sampled at grant only.
        hold_cycles = 24'd5;
        req_valid   = 4'b0001;
        step("h5_grant");
        req_valid = 4'b0000;
        cnt = 0;
        for (int s = 0; s < 8; s++) begin
            step("h5_show");
            if (s == 1) hold_cycles = 24'd1;
            if (obs_led == 8'h11) cnt++;
        end
        check("h5_len", 32'(cnt), 32'd5);

        // enable low mid-display: display completes, no new grant.
        hold_cycles = 24'd4;
        req_valid   = 4'b0001;
        step("en_grant");
        enable    = 1'b0;
        req_valid = 4'b1111;
        cnt = 0;
        zero_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            step("en_off");
            if (obs_ready != '0) zero_cnt++;
            if (obs_led == 8'h11) cnt++;
        end
        check("en_len", 32'(cnt), 32'd4);
        check("en_no_ready", 32'(zero_cnt), 32'd0);
        enable = 1'b1;
        step("en_resume");
        check("en_resume_winner", 32'(obs_ready), 32'h2);

        // Reset in display cycle 2 of 4.
        req_valid = 4'b0000;
        step("mid_show1");
        req_valid = 4'b1001;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_led",    32'(led),       32'h0);
        check("mid_rst_active", 32'(active),    32'h0);
        check("mid_rst_ready",  32'(req_ready), 32'h0);
        reset_model();
        step("mid_rst_a");
        step("mid_rst_b");
        rst_n = 1'b1;
        step("mid_rel");
        check("mid_rel_winner", 32'(obs_ready), 32'h1);

        // Random traffic against the model.
        for (int s = 0; s < 400; s++) begin
            req_valid   = 4'($urandom);
            req_pattern = 32'($urandom);
            enable      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) hold_cycles = 24'($urandom_range(0, 4));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the LED bank (2..16).
REQ-002 Parameter LED_WIDTH, default 8, LED bus width.
REQ-003 Parameter HOLD_WIDTH, default 24, hold-counter width; computed by the instantiating top level, not inside the module.
REQ-004 Port rst_n  input  1  reset, active-low, asynchronous assert.
REQ-005 Port clk  input  1  single clock; all logic on posedge clk.
REQ-006 Port enable  input  1  1 = new grants allowed.
REQ-007 Port hold_cycles  input  HOLD_WIDTH  display time per grant in clk cycles; sampled at the grant.
REQ-008 Port req_valid  input  NUM_REQ  per-requester pattern valid.
REQ-009 Port req_pattern  input  NUM_REQ*LED_WIDTH  requester i pattern in bits [i*LED_WIDTH +: LED_WIDTH].
REQ-010 Port req_ready  output  NUM_REQ  one-hot grant strobe; transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-011 Port led  output  LED_WIDTH  registered LED drive.
REQ-012 Port grant_idx  output  $clog2(NUM_REQ)  registered index of the requester currently displayed.
REQ-013 Port active  output  1  registered; 1 while a pattern is displayed.

Function
REQ-014 The FSM SHALL have two states: IDLE (led = 0) and SHOW (led = granted pattern).
REQ-015 An arbitration cycle SHALL be any cycle in IDLE, or the final SHOW cycle (hold count = 0), in which enable = 1.
REQ-016 In an arbitration cycle with any req_valid bit = 1, req_ready SHALL assert, combinationally and in the same cycle, for exactly one winner; otherwise req_ready = 0.
REQ-017 The winner SHALL be the first valid index searched round-robin from (last granted index + 1) mod NUM_REQ.
REQ-018 On transfer, the next cycle SHALL have led = winner pattern, grant_idx = winner, active = 1, state = SHOW, and last granted index = winner.
REQ-019 Each granted pattern SHALL be displayed for exactly max(hold_cycles, 1) cycles; hold_cycles = 0 SHALL be treated as 1.
REQ-020 The hold counter SHALL load max(hold_cycles, 1) - 1 at grant and decrement once per SHOW cycle; changes to hold_cycles after the grant SHALL have no effect.
REQ-021 If a transfer occurs in the final SHOW cycle, the next pattern SHALL follow with no gap (back-to-back).
REQ-022 If the final SHOW cycle has no transfer (no valid, or enable = 0), the next cycle SHALL have state = IDLE, led = 0, and active = 0; grant_idx SHALL hold its value.
REQ-023 Deasserting enable mid-SHOW SHALL NOT truncate the current display.
REQ-024 Requesters keep req_valid and req_pattern stable until transfer; a valid withdrawn before ready SHALL be ignored with no error.
REQ-025 Latency: req_valid rising in IDLE at cycle t gives req_ready at t and led at t+1.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state = IDLE, led = 0, grant_idx = 0, active = 0, hold count = 0, and last granted index = NUM_REQ-1, so requester 0 has first priority.
REQ-027 req_ready SHALL be 0 while rst_n = 0.
REQ-028 Reset asserted mid-SHOW SHALL abandon the display with no transfer.
REQ-029 Release is synchronised externally; the first arbitration cycle is the first clk edge after release.

Structure
REQ-030 Package led_pkg SHALL hold the FSM state typedef (IDLE, SHOW).
REQ-031 The round-robin priority picker SHALL be one combinational sub-module, rr_arbiter, with inputs request vector and last index, and output one-hot grant plus index.
REQ-032 Counter, FSM, and output registers SHALL reside in led_arbiter.

Verification (NUM_REQ=4, LED_WIDTH=8)
REQ-033 Reset test: after reset, led=0x00, active=0, req_ready=0; req_valid=4'b0001 with pattern 0xA5 and hold=3 -> req_ready=0001 same cycle; led=0xA5 for exactly 3 cycles, then 0x00.
REQ-034 Round-robin test: req_valid=4'b1111 held, hold=2 -> grant order 0,1,2,3,0, back-to-back, each shown 2 cycles with no 0x00 gap.
REQ-035 Hold=0 test: hold=0 -> each pattern shown 1 cycle; hold changed from 5 to 1 mid-SHOW does not alter the current display length of 5.
REQ-036 Enable test: enable=0 during SHOW with hold=4 -> display completes 4 cycles, returns to IDLE, and no ready asserts until enable=1.
REQ-037 Reset mid-operation: rst_n low during SHOW cycle 2 of 4 -> led=0x00 and active=0 immediately; after release req 0 wins over req 3 when both are valid.
